// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Unused upper bits must be zero; odd parity inverts the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divide-by-DIV tick generator; tick_o is high for one clock every DIV clocks.
module uart_baud_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // Restart realigns the phase so the first tick lands DIV clocks later.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART: ready/valid byte interfaces, configurable framing,
// oversampled RX with start validation, parity/framing/overrun reporting.
module uart_param_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned RX_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [1:0]  PAR_MODE = 2'(PARITY);
    localparam bit          HAS_PAR  = (PARITY != 0);
    localparam int unsigned BCW      = 4;
    localparam int unsigned TCW      = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] T_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] T_HALF = TCW'(OVERSAMPLE / 2 - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
        $error("uart_param_core: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_err_parity
        $error("uart_param_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
        $error("uart_param_core: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_err_oversample
        $error("uart_param_core: OVERSAMPLE must be even and >= 8");
    end
    if (RX_DIV < 1 || BAUD_DIV < OVERSAMPLE) begin : g_err_divider
        $error("uart_param_core: clock too slow for BAUD*OVERSAMPLE");
    end

    // ---------------------------------------------------------------- TX path
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic [BCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tx_rdy_q, tx_rdy_d;
    logic                 tx_restart_c;
    logic                 tx_tick;

    uart_baud_gen #(.DIV(BAUD_DIV)) u_tx_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (tx_restart_c),
        .tick_o    (tx_tick)
    );

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_sh_d      = tx_sh_q;
        tx_par_d     = tx_par_q;
        tx_cnt_d     = tx_cnt_q;
        tx_d         = tx_q;
        tx_rdy_d     = tx_rdy_q;
        tx_restart_c = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid && tx_rdy_q) begin
                    tx_sh_d      = tx_data;
                    tx_par_d     = parity_bit(MAX_DATA_BITS'(tx_data), PAR_MODE);
                    tx_d         = 1'b0;
                    tx_rdy_d     = 1'b0;
                    tx_restart_c = 1'b1;
                    tx_state_d   = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d       = tx_sh_q[0];
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_cnt_q == BCW'(DATA_BITS - 1)) begin
                        tx_cnt_d = '0;
                        if (HAS_PAR) begin
                            tx_d       = tx_par_q;
                            tx_state_d = TX_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            tx_state_d = TX_STOP;
                        end
                    end else begin
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                        tx_cnt_d = tx_cnt_q + BCW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_d       = 1'b1;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_cnt_q == BCW'(STOP_BITS - 1)) begin
                        tx_rdy_d   = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_rdy_d   = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_rdy_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_rdy_q;

    // ---------------------------------------------------------------- RX path
    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TCW-1:0]       rx_tcnt_q, rx_tcnt_d;
    logic [BCW-1:0]       rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_pacc_q, rx_pacc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_tick;
    logic                 rx_samp_c;
    logic                 rx_done_c;
    logic                 rx_hs_c;

    uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (1'b0),
        .tick_o    (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_sh_d    = rx_sh_q;
        rx_pacc_d  = rx_pacc_q;
        rx_done_c  = 1'b0;
        rx_samp_c  = rx_tick && (rx_tcnt_q == T_LAST);
        if (rx_tick) begin
            rx_tcnt_d = rx_samp_c ? '0 : rx_tcnt_q + TCW'(1);
        end
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_tcnt_d = '0;
                if (rx_tick && !rx_s_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick && (rx_tcnt_q == T_HALF)) begin
                    rx_tcnt_d  = '0;
                    rx_bcnt_d  = '0;
                    rx_pacc_d  = 1'b0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_samp_c) begin
                    rx_sh_d = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == BCW'(DATA_BITS - 1)) begin
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bcnt_d = rx_bcnt_q + BCW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_samp_c) begin
                    rx_pacc_d  = rx_s_q ^ parity_bit(MAX_DATA_BITS'(rx_sh_q), PAR_MODE);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_samp_c) begin
                    rx_done_c  = 1'b1;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                rx_tcnt_d = '0;
                if (rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_tcnt_d  = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // A completion coinciding with a handshake replaces the word rather than overrunning.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_hs_c    = rx_valid_q && rx_ready;
        if (rx_hs_c) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (rx_done_c) begin
            if (!rx_valid_q || rx_hs_c) begin
                rx_data_d  = rx_sh_q;
                rx_perr_d  = rx_pacc_q;
                rx_ferr_d  = !rx_s_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_pacc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_pacc_q  <= rx_pacc_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule
